rr_thermo_arbiter: RTL and testbench
====================================

# rr_thermo_arbiter

Parametrised round-robin arbiter with registered grant, grant-hold until release, and thermometer-mask priority rotation. It arbitrates `N_REQ` requesters for a shared resource, holds the winner until it signals `done` or drops its request, then rotates priority to the requester after the last winner. It is the next-generation arbitration stage of the design, replacing the single-cycle mask register with a full grant/release handshake.

## Interface
- `N_REQ`, default 4: number of request lines; must be ≥ 2.
- `MAX_HOLD`, default 8: maximum consecutive grant cycles; used only when `ARB_HOLD_LIMIT_EN` is defined; must be ≥ 1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req`  in  N_REQ  request vector; bit i is held high while requester i wants the resource.
- `done`  in  1  pulse from the current grantee: release the grant at this edge.
- `gnt`  out  N_REQ  one-hot grant, registered; all zeros when idle.
- `gnt_id`  out  $clog2(N_REQ)  binary index of the grantee; valid when `busy`=1.
- `busy`  out  1  high whenever `gnt` is nonzero.

## Operation
- **Reset values:** `gnt`=0, `gnt_id`=0, `busy`=0. Priority mask = all ones, so the lowest index wins first. Hold counter = 0.
- **States:**
  - IDLE (`busy`=0).
  - GRANT (`busy`=1, exactly one `gnt` bit set).
- **Arbitration function:**
  - `masked = req & mask`.
  - If `masked` ≠ 0, the winner is the lowest set bit of `masked`.
  - Otherwise the winner is the lowest set bit of `req` (unmasked fallback).
  - If `req`=0 there is no winner.
- **Mask update:** on every new grant to index w, `mask` becomes the thermometer of bits strictly above w, i.e. `~((1<<(w+1))-1)` truncated to N_REQ bits. For w = N_REQ-1 the mask is 0, which forces wrap-around through the fallback.
- **IDLE:** if `req` ≠ 0, register the winner into `gnt`/`gnt_id` and go to GRANT.
- **GRANT release:** a release occurs at an edge where any of the following holds:
  - `done`=1;
  - the grantee's `req` bit = 0;
  - the hold limit is reached (see Configuration).
  - Simultaneous release causes count as one release.
- **On release:**
  - Arbitration runs in the same cycle using the mask from the current grant. The current grantee's `req` bit is masked out, so another requester wins if one is present.
  - If the grantee is the only requester, the fallback re-grants it.
  - If no requests remain, return to IDLE with `gnt`=0.
- **Without a release:** `gnt` is held unchanged regardless of other `req` activity.
- `done` while IDLE is ignored.
- `req` bits of non-grantees may toggle freely and never glitch `gnt`.

## Timing
- Request-to-grant latency is 1 cycle: `req` sampled at edge k gives `gnt` valid after edge k.
- Back-to-back handoff has zero bubble: a release at edge k gives the next grantee's `gnt` after edge k, with no idle cycle between.
- `gnt`, `gnt_id`, `busy` and `mask` are all flops; outputs carry no combinational path from inputs.
- Asserting `rst` mid-grant clears `gnt`/`busy` immediately (asynchronously) and restores the all-ones mask. After `rst` deasserts, arbitration restarts from index 0.
- Hold counter:
  - Cleared on every new grant, including a re-grant.
  - Increments each cycle the grant is held.
  - Width is $clog2(MAX_HOLD+1); saturates at MAX_HOLD.

## Configuration
- **`ARB_HOLD_LIMIT_EN` defined:**
  - When the grant has been asserted for MAX_HOLD consecutive cycles and any other `req` bit is set, the grant is force-released at the edge ending cycle MAX_HOLD and rotates to the next requester.
  - If no other request is pending, the grant continues and the counter stays saturated.
- **`ARB_HOLD_LIMIT_EN` not defined:**
  - No hold counter is built and `MAX_HOLD` is ignored.
  - A grant lasts until `done` or until the grantee's `req` drops.

## Test plan
- **Reset and first grant:** hold `rst`=0 → `gnt`=0000, `gnt_id`=0, `busy`=0. Release `rst`, apply `req`=0101 → `gnt`=0001 one cycle later.
- **Full rotation:** hold `req`=1111 and pulse `done` in each granted cycle → `gnt` sequence 0001, 0010, 0100, 1000, 0001 with no idle cycles.
- **Wrap and fallback:**
  - After a grant to index 3, apply `req`=0100 → `gnt`=0100.
  - With `req`=0100 only, pulse `done` → `gnt` stays 0100 (re-grant), hold counter cleared.
- **Grantee drops request:** with `gnt`=0010 and `req` changing from 1011 to 1001 → next cycle `gnt`=1000. `done`=1 in the same cycle as the drop gives the same single release.
- **Hold limit:** `N_REQ`=4, `MAX_HOLD`=8, `req`=0011, `done`=0.
  - With the macro: `gnt`=0001 for 8 cycles, then 0010 for 8 cycles, then 0001.
  - Without the macro: `gnt`=0001 indefinitely.
- **Reset mid-grant:** assert `rst` while `gnt`=0100 and `req`=1111 → `gnt`=0000 immediately. After release, the first grant is 0001.

Source files
------------

// File: rtl/rr_thermo_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, a grant/release handshake and
// thermometer-mask priority rotation. Optional grant hold limit: define ARB_HOLD_LIMIT_EN.
module rr_thermo_arbiter #(
   parameter int unsigned N_REQ    = 4,
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req_i,
   input  logic                     done_i,
   output logic [N_REQ-1:0]         gnt_o,
   output logic [$clog2(N_REQ)-1:0] gnt_id_o,
   output logic                     busy_o
);
   localparam int unsigned IdW = $clog2(N_REQ);

   if (N_REQ < 2) begin : g_bad_n_req
      $error("rr_thermo_arbiter: N_REQ must be at least 2");
   end
   if (MAX_HOLD < 1) begin : g_bad_max_hold
      $error("rr_thermo_arbiter: MAX_HOLD must be at least 1");
   end

   typedef enum logic [0:0] {StIdle = 1'b0, StGrant = 1'b1} state_e;

   state_e           state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [N_REQ-1:0] mask_q, mask_d;
   logic [IdW-1:0]   gnt_id_q, gnt_id_d;

   logic [N_REQ-1:0] req_oth, masked, cand;
   logic [IdW-1:0]   win_id;
   logic             win_vld;
   logic             new_grant;
   logic             release_c;
   logic             hold_hit;

   // Others above the last winner first, then any other requester, then the grantee itself.
   always_comb begin
      req_oth = req_i & ~gnt_q;
      masked  = req_oth & mask_q;
      if (|masked) begin
         cand = masked;
      end else if (|req_oth) begin
         cand = req_oth;
      end else begin
         cand = req_i;
      end
      win_vld = |cand;
      win_id  = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (cand[i]) win_id = IdW'(i);
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      gnt_id_d  = gnt_id_q;
      mask_d    = mask_q;
      new_grant = 1'b0;
      release_c = 1'b0;
      unique case (state_q)
         StIdle: begin
            new_grant = win_vld;
         end
         StGrant: begin
            release_c = done_i | ~(|(req_i & gnt_q)) | hold_hit;
            if (release_c) begin
               new_grant = win_vld;
               if (!win_vld) begin
                  state_d  = StIdle;
                  gnt_d    = '0;
                  gnt_id_d = '0;
               end
            end
         end
      endcase
      if (new_grant) begin
         state_d         = StGrant;
         gnt_d           = '0;
         gnt_d[win_id]   = 1'b1;
         gnt_id_d        = win_id;
         for (int i = 0; i < N_REQ; i++) begin
            mask_d[i] = (i > int'(win_id));
         end
      end
   end

`ifdef ARB_HOLD_LIMIT_EN
   localparam int unsigned CntW = $clog2(MAX_HOLD + 1);

   logic [CntW-1:0] hold_q, hold_d;

   // hold_q counts completed held cycles, so MAX_HOLD-1 marks the last permitted cycle.
   assign hold_hit = (state_q == StGrant) && (hold_q >= CntW'(MAX_HOLD - 1)) &&
                     (|(req_i & ~gnt_q));

   always_comb begin
      hold_d = hold_q;
      if (new_grant) begin
         hold_d = '0;
      end else if ((state_q == StGrant) && (hold_q != CntW'(MAX_HOLD))) begin
         hold_d = hold_q + CntW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_q <= '0;
      end else begin
         hold_q <= hold_d;
      end
   end
`else
   assign hold_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         gnt_q    <= '0;
         gnt_id_q <= '0;
         mask_q   <= '1;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         gnt_id_q <= gnt_id_d;
         mask_q   <= mask_d;
      end
   end

   assign gnt_o    = gnt_q;
   assign gnt_id_o = gnt_id_q;
   assign busy_o   = (state_q == StGrant);

endmodule

// File: tb/tb_rr_thermo_arbiter.sv
// Bench for rr_thermo_arbiter: directed scenarios plus random traffic against a cyclic-scan
// reference model. Hold-limit expectations follow ARB_HOLD_LIMIT_EN.
module tb_rr_thermo_arbiter;
   localparam int N        = 4;
   localparam int MAX_HOLD = 8;
`ifdef ARB_HOLD_LIMIT_EN
   localparam bit HoldEn = 1'b1;
`else
   localparam bit HoldEn = 1'b0;
`endif

   logic         clk;
   logic         rst;
   logic [N-1:0] req;
   logic         done;
   logic [N-1:0] gnt;
   logic [1:0]   gnt_id;
   logic         busy;

   int compared;
   int mismatched;

   // Reference model state: who holds the grant, who won last, cycles held so far.
   bit m_busy;
   int m_id;
   int m_last;
   int m_held;

   rr_thermo_arbiter #(
      .N_REQ   (N),
      .MAX_HOLD(MAX_HOLD)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req_i   (req),
      .done_i  (done),
      .gnt_o   (gnt),
      .gnt_id_o(gnt_id),
      .busy_o  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [N-1:0] m_gnt();
      return m_busy ? (N'(1) << m_id) : '0;
   endfunction

   // Scan cyclically starting just after the last winner, skipping excl; excl is the last resort.
   function automatic int pick(input logic [N-1:0] r, input int excl);
      for (int k = 1; k <= N; k++) begin
         int idx;
         idx = (m_last + k) % N;
         if (r[idx] && idx != excl) return idx;
      end
      if (excl >= 0 && r[excl]) return excl;
      return -1;
   endfunction

   task automatic model_reset();
      m_busy = 1'b0;
      m_id   = 0;
      m_last = N - 1;
      m_held = 0;
   endtask

   task automatic model_grant(input int w);
      m_busy = 1'b1;
      m_id   = w;
      m_last = w;
      m_held = 1;
   endtask

   task automatic model_step(input logic [N-1:0] r, input logic d);
      if (!m_busy) begin
         if (r != '0) model_grant(pick(r, -1));
      end else begin
         logic [N-1:0] others;
         bit           rel;
         others = r & ~(N'(1) << m_id);
         rel = d || !r[m_id] || (HoldEn && m_held >= MAX_HOLD && others != '0);
         if (rel) begin
            if (r == '0) begin
               m_busy = 1'b0;
               m_id   = 0;
            end else begin
               model_grant(pick(r, m_id));
            end
         end else if (m_held < MAX_HOLD) begin
            m_held++;
         end
      end
   endtask

   task automatic step(input logic [N-1:0] r, input logic d);
      @(negedge clk);
      req  = r;
      done = d;
      @(posedge clk);
      model_step(r, d);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst  = 1'b0;
      req  = '0;
      done = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      rst = 1'b0;
      #1;
      compared++;
      if (gnt !== 4'b0000) begin
         mismatched++;
         $display("FAIL reset_gnt: got %b want 0000", gnt);
      end
      compared++;
      if (gnt_id !== 2'd0) begin
         mismatched++;
         $display("FAIL reset_gnt_id: got %0d want 0", gnt_id);
      end
      compared++;
      if (busy !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_busy: got %b want 0", busy);
      end
      @(negedge clk);
      rst = 1'b1;
      step(4'b0101, 1'b0);
      compared++;
      if (gnt !== 4'b0001 || busy !== 1'b1 || gnt_id !== 2'd0) begin
         mismatched++;
         $display("FAIL first_grant: got gnt=%b id=%0d busy=%b want 0001/0/1", gnt, gnt_id, busy);
      end
   endtask

   task automatic test_rotation();
      logic [N-1:0] exp_seq [5];
      exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step(4'b1111, i != 0);
         compared++;
         if (gnt !== exp_seq[i] || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL rotation[%0d]: got gnt=%b busy=%b want %b/1", i, gnt, busy, exp_seq[i]);
         end
      end
   endtask

   task automatic test_wrap();
      do_reset();
      step(4'b1000, 1'b0);
      compared++;
      if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
         mismatched++;
         $display("FAIL wrap_grant3: got gnt=%b id=%0d want 1000/3", gnt, gnt_id);
      end
      step(4'b0100, 1'b0);
      compared++;
      if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
         mismatched++;
         $display("FAIL wrap_fallback: got gnt=%b id=%0d want 0100/2", gnt, gnt_id);
      end
      step(4'b0100, 1'b1);
      compared++;
      if (gnt !== 4'b0100 || busy !== 1'b1) begin
         mismatched++;
         $display("FAIL wrap_regrant: got gnt=%b busy=%b want 0100/1", gnt, busy);
      end
   endtask

   task automatic test_drop();
      for (int d = 0; d < 2; d++) begin
         do_reset();
         step(4'b0010, 1'b0);
         step(4'b1011, 1'b0);
         compared++;
         if (gnt !== 4'b0010) begin
            mismatched++;
            $display("FAIL drop_hold[%0d]: got %b want 0010", d, gnt);
         end
         step(4'b1001, d != 0);
         compared++;
         if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
            mismatched++;
            $display("FAIL drop_release[%0d]: got gnt=%b id=%0d want 1000/3", d, gnt, gnt_id);
         end
      end
   endtask

   task automatic test_hold_limit();
      do_reset();
      for (int c = 1; c <= 20; c++) begin
         logic [N-1:0] exp_g;
         step(4'b0011, 1'b0);
         if (HoldEn) exp_g = (((c - 1) / MAX_HOLD) % 2 == 0) ? 4'b0001 : 4'b0010;
         else        exp_g = 4'b0001;
         compared++;
         if (gnt !== exp_g) begin
            mismatched++;
            $display("FAIL hold_limit[%0d]: got %b want %b", c, gnt, exp_g);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      step(4'b0100, 1'b0);
      step(4'b1111, 1'b0);
      compared++;
      if (gnt !== 4'b0100) begin
         mismatched++;
         $display("FAIL mid_setup: got %b want 0100", gnt);
      end
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      compared++;
      if (gnt !== 4'b0000 || busy !== 1'b0) begin
         mismatched++;
         $display("FAIL mid_async_clear: got gnt=%b busy=%b want 0000/0", gnt, busy);
      end
      @(negedge clk);
      rst = 1'b1;
      step(4'b1111, 1'b0);
      compared++;
      if (gnt !== 4'b0001) begin
         mismatched++;
         $display("FAIL mid_restart: got %b want 0001", gnt);
      end
   endtask

   task automatic test_idle_done();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step(4'b0000, 1'b1);
         compared++;
         if (gnt !== 4'b0000 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL idle_done[%0d]: got gnt=%b busy=%b want 0000/0", i, gnt, busy);
         end
      end
   endtask

   task automatic test_random();
      logic [N-1:0] r;
      do_reset();
      r = '0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 2) == 0) r = N'($urandom_range(0, 15));
         step(r, $urandom_range(0, 3) == 0);
         compared++;
         if (gnt !== m_gnt() || busy !== m_busy || (m_busy && gnt_id !== 2'(m_id))) begin
            mismatched++;
            $display("FAIL random[%0d]: req=%b got gnt=%b id=%0d busy=%b want %b/%0d/%b",
                     i, r, gnt, gnt_id, busy, m_gnt(), m_id, m_busy);
         end
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      rst        = 1'b1;
      req        = '0;
      done       = 1'b0;
      model_reset();
      test_reset();
      test_rotation();
      test_wrap();
      test_drop();
      test_hold_limit();
      test_reset_mid();
      test_idle_done();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
